fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer that drives the read address of the 16×16 instruction memory and delivers fetched words to decode. Holds the PC, buffers fetched instructions in a 2-entry queue with a valid/ready handshake to decode, and handles branch redirects and halt. Sits between `instructionMem` and the decode stage; it is the only master of the memory's read port.

## Interface
- `ADDR_W`, 16, PC and memory address width
- `DATA_W`, 16, instruction width
- `MEM_DEPTH`, 16, number of valid instruction words; addresses ≥ this are out of range
- `HALT_WORD`, 16'hF000, instruction encoding that stops fetch
- `clk` in 1, single clock, all state on rising edge
- `rst` in 1, asynchronous, active-high reset
- `imemAdr` out ADDR_W, read address to instruction memory, equals current PC
- `imemData` in DATA_W, combinational read data for `imemAdr`, valid same cycle
- `redirectValid` in 1, branch/jump taken this cycle
- `redirectPc` in ADDR_W, target PC when `redirectValid`
- `outValid` out 1, queue head holds an instruction
- `outReady` in 1, decode accepts head this cycle
- `outInstr` out DATA_W, head instruction
- `outPc` out ADDR_W, address of head instruction
- `halted` out 1, state is HALT and queue empty
- `fault` out 1, fetch stopped because PC left memory range

## Operation
- States: RUN, HALT. Reset → RUN, PC=0, queue empty, `fault`=0.
- Pop: `outValid && outReady` removes head.
- Push (RUN only): when queue has space after this cycle's pop and PC < MEM_DEPTH, push {PC, imemData}; PC ← PC+1 (ADDR_W wrap, no saturation).
- Full queue with simultaneous pop: push still occurs (count stays 2).
- Pushed word == HALT_WORD: word is pushed and delivered to decode; state → HALT, PC not incremented.
- RUN with PC ≥ MEM_DEPTH: nothing pushed; state → HALT, `fault` ← 1.
- HALT: no pushes; queue drains normally via handshake.
- Redirect (any state): highest priority. Queue flushed (any same-cycle pop is still a completed handshake, but no other entry survives), no push this cycle, PC ← redirectPc, state → RUN, `fault` ← 0.
- `imemAdr` always equals PC, including in HALT.
- Reset asserted mid-operation: immediate return to reset values, queue contents lost.

## Timing
- Reset values: `outValid`=0, `outInstr`=0, `outPc`=0, `halted`=0, `fault`=0, `imemAdr`=0.
- First instruction: `outValid`=1 after the first rising edge following reset deassertion.
- Redirect sampled at edge N → queue empty after N; target instruction valid after N+1 (one bubble).
- Throughput: 1 instruction/cycle with `outReady` held high; no bubbles except after redirect.
- `outReady` low: fetch continues until queue holds 2, then stalls with PC held.
- `halted` rises the cycle after the last queued entry pops in HALT.
- `outInstr`/`outPc` stable while `outValid && !outReady`.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `fetchCount` (16-bit, pushes) and `stallCount` (16-bit, RUN cycles with full queue and no pop); both reset to 0, wrap at 16'hFFFF, unaffected by redirect.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package `fetchPkg`: state enum (RUN, HALT), queue-entry struct {pc, instr}, default HALT_WORD constant.
- One sub-module `fetchQueue`: 2-entry FIFO with push, pop, flush, count; flush has priority over push.
- PC, state and fault logic stay in the top.

## Test plan
- Memory words 0..3 = 16'h1001,16'h1002,16'h1003,16'hF000, `outReady`=1 → four outputs on consecutive cycles with outPc 0..3, then `halted`=1, `fault`=0.
- Same program, `outReady`=0 for 5 cycles → queue holds PC 0 and 1, `imemAdr` stays 2; on release outputs resume in order, none dropped or duplicated.
- Redirect to 16'h0008 while queue holds PC 2,3 → both flushed, next output outPc=8 after one bubble cycle.
- Straight-line code with no HALT_WORD in 0..15 → after PC 15 delivered, `fault`=1, `halted`=1; then redirect to 0 → `fault`=0, fetch restarts at 0.
- Redirect and pop in the same cycle with full queue → popped entry consumed once, second entry discarded, next outPc = redirectPc.
- Assert `rst` with queue full mid-run → `outValid`=0 immediately, `imemAdr`=0; with `FETCH_PERF_EN`, counters read 0.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetchPkg;

  // Queue entries carry the default 16-bit address and instruction widths.
  localparam int unsigned EntryAddrW = 16;
  localparam int unsigned EntryDataW = 16;

  // This instruction encoding stops fetch.
  localparam logic [15:0] DefaultHaltWord = 16'hF000;

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } fetch_state_e;

  typedef struct packed {
    logic [EntryAddrW-1:0] pc;
    logic [EntryDataW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_queue.sv
// fetchQueue: 2-entry in-order instruction buffer with push, pop, flush and count.
// Flush wins over push. A same-cycle pop is still taken, but no entry survives a flush.
module fetchQueue
  import fetchPkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_entry_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t entry_q [2];
  fetch_entry_t entry_d [2];
  logic [1:0]   count_q, count_d;
  logic         do_pop, do_push;

  // Next-state logic for the storage slots and the occupancy count.
  always_comb begin
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];
    count_d    = count_q;
    do_pop     = pop_i && (count_q != 2'd0);
    do_push    = push_i && ((count_q != 2'd2) || do_pop);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) entry_d[0] = push_entry_i;
          else                 entry_d[1] = push_entry_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          entry_d[0] = entry_q[1];
          count_d    = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd2) begin
            entry_d[0] = entry_q[1];
            entry_d[1] = push_entry_i;
          end else begin
            entry_d[0] = push_entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      count_q    <= 2'd0;
    end else begin
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
      count_q    <= count_d;
    end
  end

  assign head_o  = entry_q[0];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, drives the instruction-memory read port and feeds decode
// through a 2-entry queue. It handles branch redirects, halt words and out-of-range fetch.
// Optional macro FETCH_PERF_EN adds the fetchCount and stallCount performance counters.
module fetch_controller
  import fetchPkg::*;
#(
  parameter int unsigned          ADDR_W    = EntryAddrW,
  parameter int unsigned          DATA_W    = EntryDataW,
  parameter int unsigned          MEM_DEPTH = 16,
  parameter logic [DATA_W-1:0]    HALT_WORD = DefaultHaltWord
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imemAdr,
  input  logic [DATA_W-1:0] imemData,
  input  logic              redirectValid,
  input  logic [ADDR_W-1:0] redirectPc,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outInstr,
  output logic [ADDR_W-1:0] outPc,
  output logic              halted,
  output logic              fault
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetchCount,
  output logic [15:0]       stallCount
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;

  logic              pop, push, space, in_range;
  logic [1:0]        count;
  fetch_entry_t      head, push_entry;

  // Handshake, queue space and fetch eligibility for this cycle.
  always_comb begin
    pop        = outValid && outReady;
    space      = (count != 2'd2) || pop;
    in_range   = 32'(pc_q) < MEM_DEPTH;
    push       = !redirectValid && (state_q == StRun) && space && in_range;
    push_entry = '{pc: EntryAddrW'(pc_q), instr: EntryDataW'(imemData)};
  end

  fetchQueue u_queue (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (redirectValid),
    .push_entry_i (push_entry),
    .head_o       (head),
    .count_o      (count)
  );

  // Next PC, state and fault. A redirect overrides everything else.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirectValid) begin
      pc_d    = redirectPc;
      state_d = StRun;
      fault_d = 1'b0;
    end else if (state_q == StRun) begin
      if (!in_range) begin
        state_d = StHalt;
        fault_d = 1'b1;
      end else if (push) begin
        // The halt word is still delivered, and the PC stays pointing at it.
        if (imemData == HALT_WORD) state_d = StHalt;
        else                       pc_d    = pc_q + 1'b1;
      end
    end
  end

  // PC, state and fault registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign imemAdr  = pc_q;
  assign outValid = (count != 2'd0);
  assign outInstr = DATA_W'(head.instr);
  assign outPc    = ADDR_W'(head.pc);
  assign halted   = (state_q == StHalt) && (count == 2'd0);
  assign fault    = fault_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_q, stall_count_q;

  // Free-running wrap-around counters; redirects leave them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 16'd0;
      stall_count_q <= 16'd0;
    end else begin
      if (push) fetch_count_q <= fetch_count_q + 16'd1;
      if ((state_q == StRun) && (count == 2'd2) && !pop) stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign fetchCount = fetch_count_q;
  assign stallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a randomized run
// against a queue-based reference model. It also covers FETCH_PERF_EN when defined.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imemAdr, imemData, redirectPc, outInstr, outPc;
  logic        redirectValid = 1'b0, outReady = 1'b0;
  logic        outValid, halted, fault;
`ifdef FETCH_PERF_EN
  logic [15:0] fetchCount, stallCount;
`endif

  logic [15:0] mem [16];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imemData = (imemAdr < 16'd16) ? mem[imemAdr[3:0]] : 16'hDEAD;

  fetch_controller dut (
    .clk           (clk),
    .rst           (rst),
    .imemAdr       (imemAdr),
    .imemData      (imemData),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .outValid      (outValid),
    .outReady      (outReady),
    .outInstr      (outInstr),
    .outPc         (outPc),
    .halted        (halted),
    .fault         (fault)
`ifdef FETCH_PERF_EN
    ,
    .fetchCount    (fetchCount),
    .stallCount    (stallCount)
`endif
  );

  // Reference model: an ordered list of fetched {pc, instr} pairs plus fetch status.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;
  ent_t        mq[$];
  logic [15:0] m_pc;
  bit          m_run, m_fault;
  int          m_fetch, m_stall;

  task automatic model_reset();
    mq.delete();
    m_pc = 16'd0; m_run = 1'b1; m_fault = 1'b0; m_fetch = 0; m_stall = 0;
  endtask

  task automatic model_step(input logic rv, input logic [15:0] rpc, input logic rdy);
    bit   pop;
    ent_t e;
    pop = (mq.size() > 0) && rdy;
    if (m_run && mq.size() == 2 && !pop) m_stall++;
    if (pop) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
      m_pc = rpc; m_run = 1'b1; m_fault = 1'b0;
    end else if (m_run) begin
      if (m_pc >= 16'd16) begin
        m_run = 1'b0; m_fault = 1'b1;
      end else if (mq.size() < 2) begin
        e.pc = m_pc; e.instr = mem[m_pc[3:0]];
        mq.push_back(e);
        m_fetch++;
        if (e.instr == 16'hF000) m_run = 1'b0;
        else m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic step(input logic rv, input logic [15:0] rpc, input logic rdy);
    redirectValid = rv; redirectPc = rpc; outReady = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; redirectValid = 1'b0; redirectPc = 16'd0; outReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_linear(input logic [15:0] base);
    for (int i = 0; i < 16; i++) mem[i] = base + 16'(i);
  endtask

  task automatic test_reset();
    load_linear(16'h1000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (outValid !== 1'b0) begin n_errors++; $display("FAIL reset_outValid got %b want 0", outValid); end
    n_checks++; if (outInstr !== 16'h0) begin n_errors++; $display("FAIL reset_outInstr got %h want 0000", outInstr); end
    n_checks++; if (outPc !== 16'h0) begin n_errors++; $display("FAIL reset_outPc got %h want 0000", outPc); end
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted got %b want 0", halted); end
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault got %b want 0", fault); end
    n_checks++; if (imemAdr !== 16'h0) begin n_errors++; $display("FAIL reset_imemAdr got %h want 0000", imemAdr); end
  endtask

  task automatic test_program();
    logic [15:0] prog [4];
    prog[0] = 16'h1001; prog[1] = 16'h1002; prog[2] = 16'h1003; prog[3] = 16'hF000;
    load_linear(16'h5000);
    for (int i = 0; i < 4; i++) mem[i] = prog[i];
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'd0, 1'b1);
      n_checks++;
      if (outValid !== 1'b1 || outPc !== 16'(i) || outInstr !== prog[i]) begin
        n_errors++;
        $display("FAIL prog_out%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, outValid, outPc, outInstr, 16'(i), prog[i]);
      end
    end
    step(1'b0, 16'd0, 1'b1);
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL prog_halted got %b want 1", halted); end
    n_checks++; if (outValid !== 1'b0) begin n_errors++; $display("FAIL prog_drained got %b want 0", outValid); end
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL prog_fault got %b want 0", fault); end
    n_checks++; if (imemAdr !== 16'd3) begin n_errors++; $display("FAIL prog_pc_held got %h want 0003", imemAdr); end
`ifdef FETCH_PERF_EN
    n_checks++; if (fetchCount !== 16'd4) begin n_errors++; $display("FAIL prog_fetchCount got %0d want 4", fetchCount); end
    n_checks++; if (stallCount !== 16'd0) begin n_errors++; $display("FAIL prog_stallCount got %0d want 0", stallCount); end
`endif
  endtask

  task automatic test_stall();
    mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'hF000;
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 1'b0);
    n_checks++; if (imemAdr !== 16'd2) begin n_errors++; $display("FAIL stall_imemAdr got %h want 0002", imemAdr); end
`ifdef FETCH_PERF_EN
    n_checks++; if (fetchCount !== 16'd2) begin n_errors++; $display("FAIL stall_fetchCount got %0d want 2", fetchCount); end
    n_checks++; if (stallCount !== 16'd3) begin n_errors++; $display("FAIL stall_stallCount got %0d want 3", stallCount); end
`endif
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (outValid !== 1'b1 || outPc !== 16'(k) || outInstr !== mem[k]) begin
        n_errors++;
        $display("FAIL stall_resume%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 k, outValid, outPc, outInstr, 16'(k), mem[k]);
      end
      step(1'b0, 16'd0, 1'b1);
    end
    n_checks++; if (halted !== 1'b1 || outValid !== 1'b0) begin
      n_errors++; $display("FAIL stall_end got halted=%b v=%b want halted=1 v=0", halted, outValid);
    end
  endtask

  task automatic test_redirect();
    load_linear(16'h2000);
    apply_reset();
    step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b0);
    n_checks++; if (outPc !== 16'd2 || imemAdr !== 16'd4) begin
      n_errors++; $display("FAIL redir_pre got pc=%h adr=%h want pc=0002 adr=0004", outPc, imemAdr);
    end
    step(1'b1, 16'h0008, 1'b0);
    n_checks++; if (outValid !== 1'b0) begin n_errors++; $display("FAIL redir_flush got %b want 0", outValid); end
    n_checks++; if (imemAdr !== 16'h0008) begin n_errors++; $display("FAIL redir_adr got %h want 0008", imemAdr); end
    step(1'b0, 16'd0, 1'b0);
    n_checks++; if (outValid !== 1'b1 || outPc !== 16'h0008 || outInstr !== 16'h2008) begin
      n_errors++;
      $display("FAIL redir_target got v=%b pc=%h instr=%h want v=1 pc=0008 instr=2008", outValid, outPc, outInstr);
    end
  endtask

  task automatic test_fault();
    load_linear(16'h4000);
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 16'd0, 1'b1);
      n_checks++;
      if (outValid !== 1'b1 || outPc !== 16'(k)) begin
        n_errors++; $display("FAIL fault_seq%0d got v=%b pc=%h want v=1 pc=%h", k, outValid, outPc, 16'(k));
      end
    end
    step(1'b0, 16'd0, 1'b1);
    n_checks++; if (fault !== 1'b1) begin n_errors++; $display("FAIL fault_set got %b want 1", fault); end
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL fault_halted got %b want 1", halted); end
    step(1'b1, 16'd0, 1'b1);
    n_checks++; if (fault !== 1'b0 || halted !== 1'b0 || imemAdr !== 16'd0) begin
      n_errors++; $display("FAIL fault_clear got fault=%b halted=%b adr=%h want 0 0 0000", fault, halted, imemAdr);
    end
    step(1'b0, 16'd0, 1'b1);
    n_checks++; if (outValid !== 1'b1 || outPc !== 16'd0 || outInstr !== 16'h4000) begin
      n_errors++; $display("FAIL fault_restart got v=%b pc=%h instr=%h want v=1 pc=0000 instr=4000", outValid, outPc, outInstr);
    end
  endtask

  task automatic test_redirect_pop();
    load_linear(16'h3000);
    apply_reset();
    step(1'b0, 16'd0, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    n_checks++; if (outPc !== 16'd0 || imemAdr !== 16'd2) begin
      n_errors++; $display("FAIL rpop_full got pc=%h adr=%h want pc=0000 adr=0002", outPc, imemAdr);
    end
    step(1'b1, 16'd5, 1'b1);
    n_checks++; if (outValid !== 1'b0 || imemAdr !== 16'd5) begin
      n_errors++; $display("FAIL rpop_flush got v=%b adr=%h want v=0 adr=0005", outValid, imemAdr);
    end
    step(1'b0, 16'd0, 1'b1);
    n_checks++; if (outValid !== 1'b1 || outPc !== 16'd5 || outInstr !== 16'h3005) begin
      n_errors++; $display("FAIL rpop_target got v=%b pc=%h instr=%h want v=1 pc=0005 instr=3005", outValid, outPc, outInstr);
    end
    step(1'b0, 16'd0, 1'b1);
    n_checks++; if (outPc !== 16'd6) begin n_errors++; $display("FAIL rpop_next got pc=%h want 0006", outPc); end
  endtask

  task automatic test_reset_mid();
    load_linear(16'h6000);
    apply_reset();
    step(1'b0, 16'd0, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (outValid !== 1'b0) begin n_errors++; $display("FAIL rmid_outValid got %b want 0", outValid); end
    n_checks++; if (imemAdr !== 16'd0) begin n_errors++; $display("FAIL rmid_imemAdr got %h want 0000", imemAdr); end
`ifdef FETCH_PERF_EN
    n_checks++; if (fetchCount !== 16'd0 || stallCount !== 16'd0) begin
      n_errors++; $display("FAIL rmid_counters got %0d %0d want 0 0", fetchCount, stallCount);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic        rv, rdy;
    logic [15:0] rpc;
    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 9) == 0) ? 16'hF000 : (16'($urandom) & 16'h7FFF);
    apply_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      rv  = ($urandom_range(0, 19) == 0);
      rpc = 16'($urandom_range(0, 19));
      rdy = ($urandom_range(0, 9) < 7);
      model_step(rv, rpc, rdy);
      step(rv, rpc, rdy);
      n_checks++; if (imemAdr !== m_pc) begin
        n_errors++; $display("FAIL rand_imemAdr cycle %0d got %h want %h", c, imemAdr, m_pc);
      end
      n_checks++; if (outValid !== (mq.size() > 0)) begin
        n_errors++; $display("FAIL rand_outValid cycle %0d got %b want %b", c, outValid, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        n_checks++; if (outPc !== mq[0].pc || outInstr !== mq[0].instr) begin
          n_errors++;
          $display("FAIL rand_head cycle %0d got pc=%h instr=%h want pc=%h instr=%h",
                   c, outPc, outInstr, mq[0].pc, mq[0].instr);
        end
      end
      n_checks++; if (halted !== (!m_run && mq.size() == 0)) begin
        n_errors++; $display("FAIL rand_halted cycle %0d got %b want %b", c, halted, !m_run && mq.size() == 0);
      end
      n_checks++; if (fault !== m_fault) begin
        n_errors++; $display("FAIL rand_fault cycle %0d got %b want %b", c, fault, m_fault);
      end
`ifdef FETCH_PERF_EN
      n_checks++; if (fetchCount !== 16'(m_fetch) || stallCount !== 16'(m_stall)) begin
        n_errors++;
        $display("FAIL rand_counters cycle %0d got %0d %0d want %0d %0d", c, fetchCount, stallCount,
                 16'(m_fetch), 16'(m_stall));
      end
`endif
    end
  endtask

  initial begin
    redirectPc = 16'd0;
    test_reset();
    test_program();
    test_stall();
    test_redirect();
    test_fault();
    test_redirect_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
